// File: rtl/uart_sample_packetizer.sv
// uart_sample_packetizer: FIFO-buffered 16-bit samples framed as byte packets for UART TX.
// Build option: define PKT_CHECKSUM_EN to append an XOR checksum byte to every packet.
`timescale 1ns/1ps
module uart_sample_packetizer #(
    parameter int         DEPTH   = 8,
    parameter int         ADDR_W  = 3,
    parameter logic [7:0] HEADER  = 8'hA5,
    parameter int         GAP_CYC = 16
) (
    input  logic              CLK_25MHZ,
    input  logic              RSTN,
    input  logic              sample_valid,
    input  logic [15:0]       sample_data,
    output logic              sample_ready,
    output logic [7:0]        tx_byte,
    output logic              tx_dv,
    input  logic              tx_active,
    input  logic              tx_done,
    output logic [ADDR_W:0]   fifo_count,
    output logic              overflow
);

`ifdef PKT_CHECKSUM_EN
    localparam logic [1:0] LAST_IDX = 2'd3;
`else
    localparam logic [1:0] LAST_IDX = 2'd2;
`endif
    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_WAIT,
        S_GAP
    } state_t;

    state_t state, state_d;

    logic [15:0]       mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              full;
    logic              push;
    logic              pop;
    logic              fire;
    logic              adv;
    logic              gap_clr;
    logic              last_byte;
    logic              gap_done;
    logic [1:0]        idx;
    logic [GW-1:0]     gap_cnt;
    logic [15:0]       shadow;
    logic [7:0]        pkt_byte;

    assign full         = fifo_count == (ADDR_W+1)'(DEPTH);
    assign sample_ready = !full;
    assign push         = sample_valid && !full;
    assign last_byte    = idx == LAST_IDX;
    assign gap_done     = gap_cnt == GAP_LAST;

    always_ff @(posedge CLK_25MHZ) begin
        if (push) begin
            mem[wr_ptr] <= sample_data;
        end
    end

    // A rejected offer that coincides with a pop is back-pressure, not loss.
    always_ff @(posedge CLK_25MHZ or posedge RSTN) begin
        if (RSTN) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                fifo_count <= fifo_count + 1'b1;
            end else if (pop && !push) begin
                fifo_count <= fifo_count - 1'b1;
            end
            if (sample_valid && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK_25MHZ or posedge RSTN) begin
        if (RSTN) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        unique case (state)
            S_IDLE: if (fifo_count != '0) state_d = S_LOAD;
            S_LOAD: state_d = S_SEND;
            S_SEND: if (!tx_active) state_d = S_WAIT;
            S_WAIT: begin
                if (tx_done) begin
                    if (GAP_CYC != 0) begin
                        state_d = S_GAP;
                    end else begin
                        state_d = last_byte ? S_IDLE : S_SEND;
                    end
                end
            end
            S_GAP: begin
                if (gap_done) begin
                    state_d = last_byte ? S_IDLE : S_SEND;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pop     = 1'b0;
        fire    = 1'b0;
        adv     = 1'b0;
        gap_clr = 1'b0;
        unique case (1'b1)
            state == S_LOAD: pop = 1'b1;
            state == S_SEND: fire = !tx_active;
            state == S_WAIT: begin
                gap_clr = tx_done;
                adv     = tx_done && (GAP_CYC == 0);
            end
            state == S_GAP:  adv = gap_done;
            default: ;
        endcase
    end

    always_comb begin
        pkt_byte = HEADER;
        unique case (idx)
            2'd1: pkt_byte = shadow[15:8];
            2'd2: pkt_byte = shadow[7:0];
`ifdef PKT_CHECKSUM_EN
            2'd3: pkt_byte = shadow[15:8] ^ shadow[7:0];
`endif
            default: pkt_byte = HEADER;
        endcase
    end

    always_ff @(posedge CLK_25MHZ or posedge RSTN) begin
        if (RSTN) begin
            idx     <= '0;
            gap_cnt <= '0;
            shadow  <= '0;
            tx_byte <= 8'h00;
            tx_dv   <= 1'b0;
        end else begin
            tx_dv <= fire;
            if (fire) begin
                tx_byte <= pkt_byte;
            end
            if (pop) begin
                shadow <= mem[rd_ptr];
                idx    <= '0;
            end else if (adv) begin
                idx <= idx + 1'b1;
            end
            if (gap_clr) begin
                gap_cnt <= '0;
            end else if (state == S_GAP) begin
                gap_cnt <= gap_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_sample_packetizer.sv
// tb_uart_sample_packetizer: random + directed bench with a UART TX responder
// and a queue-based model of the expected byte stream.
`timescale 1ns/1ps
module tb_uart_sample_packetizer;

    localparam int         DEPTH   = 8;
    localparam int         ADDR_W  = 3;
    localparam int         GAP_CYC = 16;
    localparam logic [7:0] HEADER  = 8'hA5;
`ifdef PKT_CHECKSUM_EN
    localparam int NB = 4;
`else
    localparam int NB = 3;
`endif

    logic            CLK_25MHZ = 1'b0;
    logic            RSTN = 1'b1;
    logic            sample_valid = 1'b0;
    logic [15:0]     sample_data = 16'h0;
    logic            sample_ready;
    logic [7:0]      tx_byte;
    logic            tx_dv;
    logic            tx_active;
    logic            tx_done = 1'b0;
    logic [ADDR_W:0] fifo_count;
    logic            overflow;

    logic model_active = 1'b0;
    logic force_active = 1'b0;
    assign tx_active = model_active | force_active;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [7:0] exp_q[$];
    int dv_count = 0;
    int done_count = 0;
    int n_pushed = 0;
    int n_started = 0;
    int byte_pos = 0;
    int lat_fixed = 10;
    int done_cyc = 0;
    bit have_done = 1'b0;
    bit model_busy = 1'b0;

    uart_sample_packetizer #(
        .DEPTH(DEPTH), .ADDR_W(ADDR_W),
        .HEADER(HEADER), .GAP_CYC(GAP_CYC)
    ) dut (
        .CLK_25MHZ(CLK_25MHZ),
        .RSTN(RSTN),
        .sample_valid(sample_valid),
        .sample_data(sample_data),
        .sample_ready(sample_ready),
        .tx_byte(tx_byte),
        .tx_dv(tx_dv),
        .tx_active(tx_active),
        .tx_done(tx_done),
        .fifo_count(fifo_count),
        .overflow(overflow)
    );

    always #20 CLK_25MHZ = ~CLK_25MHZ;
    always @(posedge CLK_25MHZ) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void enqueue(input logic [15:0] d);
        exp_q.push_back(HEADER);
        exp_q.push_back(d[15:8]);
        exp_q.push_back(d[7:0]);
        if (NB == 4) exp_q.push_back(d[15:8] ^ d[7:0]);
        n_pushed++;
    endfunction

    // UART TX responder: busy for a few clocks per byte, then pulses tx_done.
    initial begin : uart_model
        logic [7:0] b;
        int lat;
        forever begin
            @(posedge CLK_25MHZ); #1;
            if (!RSTN && tx_dv) begin
                b = tx_byte;
                dv_count++;
                model_busy = 1'b1;
                check("pending", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) check("byte", 32'(b), 32'(exp_q.pop_front()));
                if (have_done) check("gap", 32'((cyc - done_cyc) > GAP_CYC), 1);
                if (byte_pos == 0) n_started++;
                byte_pos = (byte_pos + 1) % NB;
                model_active = 1'b1;
                lat = (lat_fixed != 0) ? lat_fixed : int'($urandom_range(1, 12));
                repeat (lat) begin
                    @(posedge CLK_25MHZ); #1;
                    check("dv_pulse", 32'(tx_dv), 0);
                    check("byte_hold", 32'(tx_byte), 32'(b));
                end
                model_active = 1'b0;
                tx_done = 1'b1;
                done_cyc = cyc;
                have_done = 1'b1;
                done_count++;
                @(posedge CLK_25MHZ); #1;
                tx_done = 1'b0;
                check("dv_at_done", 32'(tx_dv), 0);
                model_busy = 1'b0;
            end
        end
    end

    task automatic push(input logic [15:0] d, input bit accept);
        sample_valid = 1'b1;
        sample_data = d;
        if (accept) enqueue(d);
        @(posedge CLK_25MHZ); #1;
        sample_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLK_25MHZ);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || model_busy) && n < 20000) begin
            @(posedge CLK_25MHZ); #1;
            n++;
        end
        check("drain", 32'(exp_q.size()), 0);
        idle(GAP_CYC + 8);
    endtask

    task automatic wait_done(input int target);
        int n = 0;
        do begin
            @(posedge CLK_25MHZ); #2;
            n++;
        end while (done_count < target && n < 5000);
        check("done_wait", 32'(done_count >= target), 1);
    endtask

    task automatic clear_model();
        exp_q.delete();
        have_done = 1'b0;
        byte_pos = 0;
        n_pushed = 0;
        n_started = 0;
    endtask

    task automatic apply_reset();
        RSTN = 1'b1;
        sample_valid = 1'b0;
        idle(2);
        clear_model();
        RSTN = 1'b0;
    endtask

    initial begin : main
        int base;
        int n;
        #5;
        check("rst_count", 32'(fifo_count), 0);
        check("rst_ready", 32'(sample_ready), 1);
        check("rst_dv", 32'(tx_dv), 0);
        check("rst_byte", 32'(tx_byte), 0);
        check("rst_ovf", 32'(overflow), 0);
        idle(3);
        RSTN = 1'b0;
        idle(2);

        // Single sample, fixed 10-clock UART latency.
        base = dv_count;
        push(16'h1234, 1);
        drain();
        check("t1_dvs", 32'(dv_count - base), 32'(NB));
        check("t1_count", 32'(fifo_count), 0);

        // UART held busy: nothing may start.
        base = dv_count;
        force_active = 1'b1;
        push(16'hBEEF, 1);
        idle(50);
        check("t2_stall_dv", 32'(dv_count - base), 0);
        check("t2_popped", 32'(fifo_count), 0);
        force_active = 1'b0;
        drain();
        check("t2_dvs", 32'(dv_count - base), 32'(NB));

        // Two back-to-back samples, random latency, order and gap.
        lat_fixed = 0;
        base = dv_count;
        push(16'hAAAA, 1);
        push(16'h5555, 1);
        drain();
        check("t4_dvs", 32'(dv_count - base), 32'(2 * NB));

        // Fill the FIFO behind a stalled packet, then overflow it.
        force_active = 1'b1;
        push(16'h0101, 1);
        idle(4);
        for (int i = 0; i < DEPTH; i++) push(16'($urandom), 1);
        check("t3_full", 32'(fifo_count), 32'(DEPTH));
        check("t3_ready", 32'(sample_ready), 0);
        check("t3_ovf0", 32'(overflow), 0);
        push(16'hFFFF, 0);
        check("t3_ovf1", 32'(overflow), 1);
        check("t3_keep", 32'(fifo_count), 32'(DEPTH));
        force_active = 1'b0;
        drain();
        check("t3_empty", 32'(fifo_count), 0);
        check("t3_sticky", 32'(overflow), 1);

        // Offer a sample exactly in the pop cycle of a full FIFO.
        // Pop lands GAP_CYC clocks + IDLE + LOAD after the last tx_done.
        apply_reset();
        check("rst2_ovf", 32'(overflow), 0);
        lat_fixed = 3;
        force_active = 1'b1;
        push(16'h0F0F, 1);
        idle(4);
        for (int i = 0; i < DEPTH; i++) push(16'($urandom), 1);
        check("t6_full", 32'(fifo_count), 32'(DEPTH));
        base = done_count;
        force_active = 1'b0;
        wait_done(base + NB);
        repeat (GAP_CYC + 2) @(posedge CLK_25MHZ);
        #1;
        sample_valid = 1'b1;
        sample_data = 16'hDEAD;
        @(posedge CLK_25MHZ); #1;
        sample_valid = 1'b0;
        check("t6_count", 32'(fifo_count), 32'(DEPTH - 1));
        check("t6_ovf", 32'(overflow), 0);
        drain();
        check("t6_empty", 32'(fifo_count), 0);

        // Asynchronous reset between byte 1 and byte 2.
        lat_fixed = 5;
        push(16'h1357, 1);
        push(16'h2468, 1);
        wait_done(done_count + 1);
        idle(3);
        #5;
        RSTN = 1'b1;
        #1;
        check("t5_dv", 32'(tx_dv), 0);
        check("t5_byte", 32'(tx_byte), 0);
        check("t5_count", 32'(fifo_count), 0);
        check("t5_ready", 32'(sample_ready), 1);
        check("t5_ovf", 32'(overflow), 0);
        idle(2);
        clear_model();
        RSTN = 1'b0;
        base = dv_count;
        idle(200);
        check("t5_quiet", 32'(dv_count - base), 0);

        // Random traffic, never exceeding what the FIFO can hold.
        lat_fixed = 0;
        n = 0;
        while (n_pushed < 40 && n < 5000) begin
            if ((n_pushed - n_started) < DEPTH && $urandom_range(0, 2) == 0) begin
                check("rnd_ready", 32'(sample_ready), 1);
                push(16'($urandom), 1);
            end else begin
                idle(1);
            end
            n++;
        end
        check("rnd_pushed", 32'(n_pushed), 40);
        drain();
        check("rnd_count", 32'(fifo_count), 0);
        check("rnd_ovf", 32'(overflow), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
